// File: rtl/ppg_window_stats.sv
// Windowed PPG statistics: per-channel AC (max-min), DC (mean) and clip flags over
// 2**LOG2_WIN samples taken on LED phase falling edges, plus SpO2 ratio product terms.
module ppg_window_stats #(
    parameter int         LOG2_WIN = 5,
    parameter logic [7:0] CLIP_LO  = 8'd10,
    parameter logic [7:0] CLIP_HI  = 8'd245
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        en,
    input  logic        LED_RED,
    input  logic        LED_IR,
    input  logic [7:0]  RED_ADC_Value,
    input  logic [7:0]  IR_ADC_Value,
    output logic [7:0]  red_ac,
    output logic [7:0]  red_dc,
    output logic [7:0]  ir_ac,
    output logic [7:0]  ir_dc,
    output logic [15:0] ratio_num,
    output logic [15:0] ratio_den,
    output logic        red_clip,
    output logic        ir_clip,
    output logic        stats_valid
);

    localparam int SW = 8 + LOG2_WIN;
    localparam int CW = LOG2_WIN + 1;
    localparam logic [CW-1:0] FULL    = CW'(2 ** LOG2_WIN);
    localparam logic [CW-1:0] FULL_M1 = CW'(2 ** LOG2_WIN - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CALC    = 2'd2;

    logic [1:0] state, state_nxt;

    // Channel index 0 is RED, 1 is IR throughout.
    logic [1:0]          led_q;
    logic [1:0]          stb;
    logic [1:0][7:0]     x;
    logic [1:0][SW-1:0]  sum;
    logic [1:0][7:0]     mn, mx;
    logic [1:0][CW-1:0]  cnt;
    logic [1:0]          clip;
    logic [1:0]          full_now, full_next;
    logic [1:0][7:0]     ac_new, dc_new;
    logic                accepting;

    assign x         = {IR_ADC_Value, RED_ADC_Value};
    assign stb       = led_q & ~{LED_IR, LED_RED};
    assign accepting = (state == S_COLLECT) && en;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full_now[c]  = (cnt[c] == FULL);
            full_next[c] = full_now[c] || ((cnt[c] == FULL_M1) && stb[c]);
            ac_new[c]    = mx[c] - mn[c];
            dc_new[c]    = sum[c][LOG2_WIN +: 8];
        end
    end

    // CALC is entered on the same edge that absorbs the closing strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (en) state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (!en)             state_nxt = S_IDLE;
                else if (&full_next) state_nxt = S_CALC;
            end
            S_CALC:    state_nxt = en ? S_COLLECT : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= S_IDLE;
            led_q <= '0;
        end else begin
            state <= state_nxt;
            led_q <= {LED_IR, LED_RED};
        end
    end

    // Anything outside an enabled COLLECT (IDLE, CALC, en low) discards the partial window.
    always_ff @(posedge CLK) begin
        if (rst || !accepting) begin
            for (int c = 0; c < 2; c++) begin
                sum[c]  <= '0;
                mn[c]   <= 8'hFF;
                mx[c]   <= 8'h00;
                cnt[c]  <= '0;
                clip[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (stb[c] && !full_now[c]) begin
                    sum[c] <= sum[c] + SW'(x[c]);
                    cnt[c] <= cnt[c] + CW'(1);
                    if (x[c] < mn[c]) mn[c] <= x[c];
                    if (x[c] > mx[c]) mx[c] <= x[c];
                    if ((x[c] < CLIP_LO) || (x[c] > CLIP_HI)) clip[c] <= 1'b1;
                end
            end
        end
    end

    // stats_valid is a one-cycle pulse with no back-pressure: all result outputs
    // change only on the edge that raises it and hold until the next pulse.
    always_ff @(posedge CLK) begin
        if (rst) begin
            red_ac      <= '0;
            red_dc      <= '0;
            ir_ac       <= '0;
            ir_dc       <= '0;
            ratio_num   <= '0;
            ratio_den   <= '0;
            red_clip    <= 1'b0;
            ir_clip     <= 1'b0;
            stats_valid <= 1'b0;
        end else if (state == S_CALC) begin
            red_ac      <= ac_new[0];
            red_dc      <= dc_new[0];
            ir_ac       <= ac_new[1];
            ir_dc       <= dc_new[1];
            ratio_num   <= 16'(ac_new[0]) * 16'(dc_new[1]);
            ratio_den   <= 16'(ac_new[1]) * 16'(dc_new[0]);
            red_clip    <= clip[0];
            ir_clip     <= clip[1];
            stats_valid <= 1'b1;
        end else begin
            stats_valid <= 1'b0;
        end
    end

endmodule
